// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, ALU
// operation codes, step/state encodings, instruction classes and the strobe
// bundle driven to the datapath.
package cpu_ctrl_pkg;

    localparam int OPCODE_W  = 5;
    localparam int ALUCTRL_W = 5;
    localparam int STEP_W    = 3;

    // Opcode map, IR[31:27]. 5'h1B..5'h1F are undefined.
    localparam logic [OPCODE_W-1:0] OP_LD   = 5'h00;
    localparam logic [OPCODE_W-1:0] OP_LDI  = 5'h01;
    localparam logic [OPCODE_W-1:0] OP_ST   = 5'h02;
    localparam logic [OPCODE_W-1:0] OP_ADD  = 5'h03;
    localparam logic [OPCODE_W-1:0] OP_SUB  = 5'h04;
    localparam logic [OPCODE_W-1:0] OP_AND  = 5'h05;
    localparam logic [OPCODE_W-1:0] OP_OR   = 5'h06;
    localparam logic [OPCODE_W-1:0] OP_SHR  = 5'h07;
    localparam logic [OPCODE_W-1:0] OP_SHRA = 5'h08;
    localparam logic [OPCODE_W-1:0] OP_SHL  = 5'h09;
    localparam logic [OPCODE_W-1:0] OP_ROR  = 5'h0A;
    localparam logic [OPCODE_W-1:0] OP_ROL  = 5'h0B;
    localparam logic [OPCODE_W-1:0] OP_ADDI = 5'h0C;
    localparam logic [OPCODE_W-1:0] OP_ANDI = 5'h0D;
    localparam logic [OPCODE_W-1:0] OP_ORI  = 5'h0E;
    localparam logic [OPCODE_W-1:0] OP_MUL  = 5'h0F;
    localparam logic [OPCODE_W-1:0] OP_DIV  = 5'h10;
    localparam logic [OPCODE_W-1:0] OP_NEG  = 5'h11;
    localparam logic [OPCODE_W-1:0] OP_NOT  = 5'h12;
    localparam logic [OPCODE_W-1:0] OP_BR   = 5'h13;
    localparam logic [OPCODE_W-1:0] OP_JR   = 5'h14;
    localparam logic [OPCODE_W-1:0] OP_IN   = 5'h15;
    localparam logic [OPCODE_W-1:0] OP_OUT  = 5'h16;
    localparam logic [OPCODE_W-1:0] OP_MFHI = 5'h17;
    localparam logic [OPCODE_W-1:0] OP_MFLO = 5'h18;
    localparam logic [OPCODE_W-1:0] OP_NOP  = 5'h19;
    localparam logic [OPCODE_W-1:0] OP_HALT = 5'h1A;

    // ALU operation select; ALU_NONE is driven whenever no ALU step is active.
    localparam logic [ALUCTRL_W-1:0] ALU_ADD  = 5'h00;
    localparam logic [ALUCTRL_W-1:0] ALU_SUB  = 5'h01;
    localparam logic [ALUCTRL_W-1:0] ALU_AND  = 5'h02;
    localparam logic [ALUCTRL_W-1:0] ALU_OR   = 5'h03;
    localparam logic [ALUCTRL_W-1:0] ALU_SHR  = 5'h04;
    localparam logic [ALUCTRL_W-1:0] ALU_SHRA = 5'h05;
    localparam logic [ALUCTRL_W-1:0] ALU_SHL  = 5'h06;
    localparam logic [ALUCTRL_W-1:0] ALU_ROR  = 5'h07;
    localparam logic [ALUCTRL_W-1:0] ALU_ROL  = 5'h08;
    localparam logic [ALUCTRL_W-1:0] ALU_MUL  = 5'h09;
    localparam logic [ALUCTRL_W-1:0] ALU_DIV  = 5'h0A;
    localparam logic [ALUCTRL_W-1:0] ALU_NEG  = 5'h0B;
    localparam logic [ALUCTRL_W-1:0] ALU_NOT  = 5'h0C;
    localparam logic [ALUCTRL_W-1:0] ALU_NONE = 5'h1F;

    typedef enum logic [STEP_W-1:0] {
        T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3,
        T4 = 3'd4, T5 = 3'd5, T6 = 3'd6, T7 = 3'd7
    } step_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    typedef enum logic [3:0] {
        CL_ALU_REG = 4'd0,  CL_ALU_IMM = 4'd1,  CL_LD   = 4'd2,  CL_LDI     = 4'd3,
        CL_ST      = 4'd4,  CL_MULDIV  = 4'd5,  CL_UNARY = 4'd6, CL_BR      = 4'd7,
        CL_JR      = 4'd8,  CL_IN      = 4'd9,  CL_OUT  = 4'd10, CL_MFHI    = 4'd11,
        CL_MFLO    = 4'd12, CL_NOP     = 4'd13, CL_HALT = 4'd14, CL_ILLEGAL = 4'd15
    } iclass_e;

    // Control strobes, MSB first in this order.
    typedef struct packed {
        logic PCout;  logic Zlowout; logic Zhighout; logic MDRout; logic HIout;
        logic LOout;  logic InPortout; logic Cout;  logic MARin;  logic Zin;
        logic PCin;   logic MDRin;   logic IRin;    logic Yin;    logic HIin;
        logic LOin;   logic OutPortin; logic Read;  logic Write;  logic Gra;
        logic Grb;    logic Grc;     logic Rin;     logic Rout;   logic BAout;
        logic ConIn;  logic incPC;
    } strobes_t;

    // Steps that talk to memory and may be stretched by a slow memory.
    function automatic logic f_is_mem_step(input iclass_e cls, input step_e step);
        return (step == T1) || ((step == T6) && (cls == CL_LD)) ||
               ((step == T7) && (cls == CL_ST));
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Bus between the control sequencer (master) and the CPU datapath (slave).
// mem_ready exists only when CTRL_MEM_WAIT_EN is defined.
interface control_sequencer_if;
    import cpu_ctrl_pkg::*;

    logic [31:0]          ir;
    logic                 con_ff;
    logic                 stop;
`ifdef CTRL_MEM_WAIT_EN
    logic                 mem_ready;
`endif
    logic                 run;
    logic                 illegal;
    logic [ALUCTRL_W-1:0] aluControl;
    strobes_t             strobes;

`ifdef CTRL_MEM_WAIT_EN
    modport master (input ir, input con_ff, input stop, input mem_ready,
                    output run, output illegal, output aluControl, output strobes);
    modport slave  (output ir, output con_ff, output stop, output mem_ready,
                    input run, input illegal, input aluControl, input strobes);
`else
    modport master (input ir, input con_ff, input stop,
                    output run, output illegal, output aluControl, output strobes);
    modport slave  (output ir, output con_ff, output stop,
                    input run, input illegal, input aluControl, input strobes);
`endif

endinterface

// File: rtl/control_sequencer_decode.sv
// Combinational opcode decoder: instruction class, ALU code and an
// undefined-opcode flag.
module ctrl_opcode_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [OPCODE_W-1:0]  i_opcode,
    output iclass_e              o_class,
    output logic [ALUCTRL_W-1:0] o_alu,
    output logic                 o_illegal
);

    // Map each opcode to its execute class and the ALU operation it needs.
    always_comb begin
        o_class = CL_ILLEGAL;
        o_alu   = ALU_NONE;
        case (i_opcode)
            OP_LD:   begin o_class = CL_LD;      o_alu = ALU_ADD;  end
            OP_LDI:  begin o_class = CL_LDI;     o_alu = ALU_ADD;  end
            OP_ST:   begin o_class = CL_ST;      o_alu = ALU_ADD;  end
            OP_ADD:  begin o_class = CL_ALU_REG; o_alu = ALU_ADD;  end
            OP_SUB:  begin o_class = CL_ALU_REG; o_alu = ALU_SUB;  end
            OP_AND:  begin o_class = CL_ALU_REG; o_alu = ALU_AND;  end
            OP_OR:   begin o_class = CL_ALU_REG; o_alu = ALU_OR;   end
            OP_SHR:  begin o_class = CL_ALU_REG; o_alu = ALU_SHR;  end
            OP_SHRA: begin o_class = CL_ALU_REG; o_alu = ALU_SHRA; end
            OP_SHL:  begin o_class = CL_ALU_REG; o_alu = ALU_SHL;  end
            OP_ROR:  begin o_class = CL_ALU_REG; o_alu = ALU_ROR;  end
            OP_ROL:  begin o_class = CL_ALU_REG; o_alu = ALU_ROL;  end
            OP_ADDI: begin o_class = CL_ALU_IMM; o_alu = ALU_ADD;  end
            OP_ANDI: begin o_class = CL_ALU_IMM; o_alu = ALU_AND;  end
            OP_ORI:  begin o_class = CL_ALU_IMM; o_alu = ALU_OR;   end
            OP_MUL:  begin o_class = CL_MULDIV;  o_alu = ALU_MUL;  end
            OP_DIV:  begin o_class = CL_MULDIV;  o_alu = ALU_DIV;  end
            OP_NEG:  begin o_class = CL_UNARY;   o_alu = ALU_NEG;  end
            OP_NOT:  begin o_class = CL_UNARY;   o_alu = ALU_NOT;  end
            OP_BR:   begin o_class = CL_BR;      o_alu = ALU_ADD;  end
            OP_JR:   o_class = CL_JR;
            OP_IN:   o_class = CL_IN;
            OP_OUT:  o_class = CL_OUT;
            OP_MFHI: o_class = CL_MFHI;
            OP_MFLO: o_class = CL_MFLO;
            OP_NOP:  o_class = CL_NOP;
            OP_HALT: o_class = CL_HALT;
            default: o_class = CL_ILLEGAL;
        endcase
        o_illegal = (o_class == CL_ILLEGAL);
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control sequencer: step counter T0..T7, RUN/HALT state and the
// combinational strobe decode driven to the datapath.
// Optional build macro CTRL_MEM_WAIT_EN: memory steps (fetch T1, ld T6,
// st T7) are held with strobes asserted until mem_ready is high.
module control_sequencer
    import cpu_ctrl_pkg::*;
(
    input  logic                clock,
    input  logic                clear,
    control_sequencer_if.master bus
);

    step_e                r_step;
    state_e               r_state;
    logic                 r_illegal;
    step_e                w_step_adv;
    step_e                w_step_nxt;
    state_e               w_state_nxt;
    logic                 w_illegal_nxt;
    logic                 w_hold;
    logic                 w_mem_ready;
    iclass_e              w_class;
    logic [ALUCTRL_W-1:0] w_alu_op;
    logic                 w_op_illegal;
    logic [ALUCTRL_W-1:0] w_alu_ctl;
    strobes_t             w_strobes;
    logic                 w_unused_ir;

    // Only the opcode field steers the sequence; the rest belongs to the datapath.
    assign w_unused_ir = ^bus.ir[31-OPCODE_W:0];

    ctrl_opcode_decode u_decode (
        .i_opcode  (bus.ir[31:32-OPCODE_W]),
        .o_class   (w_class),
        .o_alu     (w_alu_op),
        .o_illegal (w_op_illegal)
    );

`ifdef CTRL_MEM_WAIT_EN
    assign w_mem_ready = bus.mem_ready;
`else
    assign w_mem_ready = 1'b1;
`endif

    // Step, run/halt state and sticky illegal flag; clear aborts everything.
    always_ff @(posedge clock) begin
        if (clear) begin
            r_step    <= T0;
            r_state   <= ST_RUN;
            r_illegal <= 1'b0;
        end else begin
            r_step    <= w_step_nxt;
            r_state   <= w_state_nxt;
            r_illegal <= w_illegal_nxt;
        end
    end

    // Next step/state and strobe decode for the current step and opcode class.
    always_comb begin
        w_step_adv    = T0;
        w_state_nxt   = r_state;
        w_illegal_nxt = r_illegal;
        w_hold        = 1'b0;
        w_strobes     = '0;
        w_alu_ctl     = ALU_NONE;
        if (clear) begin
            // Aborting cycle: nothing may fire, registers reset at the edge.
            w_step_adv = T0;
        end else if (r_state == ST_HALT) begin
            w_step_adv = T0;
        end else if ((r_step == T0) && bus.stop) begin
            // Halt before fetch; T0 strobes are suppressed.
            w_state_nxt = ST_HALT;
            w_step_adv  = T0;
        end else begin
            w_hold = f_is_mem_step(w_class, r_step) && !w_mem_ready;
            case (r_step)
                T0: begin
                    w_strobes.PCout = 1'b1; w_strobes.MARin = 1'b1; w_strobes.incPC = 1'b1;
                    w_step_adv = T1;
                end
                T1: begin
                    w_strobes.Read = 1'b1; w_strobes.MDRin = 1'b1;
                    w_step_adv = T2;
                end
                T2: begin
                    w_strobes.MDRout = 1'b1; w_strobes.IRin = 1'b1;
                    w_step_adv = T3;
                end
                T3: begin
                    case (w_class)
                        CL_ALU_REG, CL_ALU_IMM: begin
                            w_strobes.Grb = 1'b1; w_strobes.Rout = 1'b1; w_strobes.Yin = 1'b1;
                            w_step_adv = T4;
                        end
                        CL_LD, CL_LDI, CL_ST: begin
                            w_strobes.Grb = 1'b1; w_strobes.BAout = 1'b1; w_strobes.Yin = 1'b1;
                            w_step_adv = T4;
                        end
                        CL_MULDIV: begin
                            w_strobes.Gra = 1'b1; w_strobes.Rout = 1'b1; w_strobes.Yin = 1'b1;
                            w_step_adv = T4;
                        end
                        CL_UNARY: begin
                            w_strobes.Grb = 1'b1; w_strobes.Rout = 1'b1; w_strobes.Zin = 1'b1;
                            w_alu_ctl  = w_alu_op;
                            w_step_adv = T4;
                        end
                        CL_BR: begin
                            w_strobes.Gra = 1'b1; w_strobes.Rout = 1'b1; w_strobes.ConIn = 1'b1;
                            w_step_adv = T4;
                        end
                        CL_JR: begin
                            w_strobes.Gra = 1'b1; w_strobes.Rout = 1'b1; w_strobes.PCin = 1'b1;
                        end
                        CL_IN: begin
                            w_strobes.InPortout = 1'b1; w_strobes.Gra = 1'b1; w_strobes.Rin = 1'b1;
                        end
                        CL_OUT: begin
                            w_strobes.Gra = 1'b1; w_strobes.Rout = 1'b1; w_strobes.OutPortin = 1'b1;
                        end
                        CL_MFHI: begin
                            w_strobes.HIout = 1'b1; w_strobes.Gra = 1'b1; w_strobes.Rin = 1'b1;
                        end
                        CL_MFLO: begin
                            w_strobes.LOout = 1'b1; w_strobes.Gra = 1'b1; w_strobes.Rin = 1'b1;
                        end
                        CL_NOP: w_step_adv = T0;
                        default: begin
                            // halt or undefined opcode: stop for good until clear
                            w_state_nxt   = ST_HALT;
                            w_illegal_nxt = r_illegal | w_op_illegal;
                        end
                    endcase
                end
                T4: begin
                    case (w_class)
                        CL_ALU_REG: begin
                            w_strobes.Grc = 1'b1; w_strobes.Rout = 1'b1; w_strobes.Zin = 1'b1;
                            w_alu_ctl  = w_alu_op;
                            w_step_adv = T5;
                        end
                        CL_ALU_IMM, CL_LD, CL_LDI, CL_ST: begin
                            w_strobes.Cout = 1'b1; w_strobes.Zin = 1'b1;
                            w_alu_ctl  = w_alu_op;
                            w_step_adv = T5;
                        end
                        CL_MULDIV: begin
                            w_strobes.Grb = 1'b1; w_strobes.Rout = 1'b1; w_strobes.Zin = 1'b1;
                            w_alu_ctl  = w_alu_op;
                            w_step_adv = T5;
                        end
                        CL_UNARY: begin
                            w_strobes.Zlowout = 1'b1; w_strobes.Gra = 1'b1; w_strobes.Rin = 1'b1;
                        end
                        CL_BR: begin
                            w_strobes.PCout = 1'b1; w_strobes.Yin = 1'b1;
                            w_step_adv = T5;
                        end
                        default: w_step_adv = T0;
                    endcase
                end
                T5: begin
                    case (w_class)
                        CL_ALU_REG, CL_ALU_IMM, CL_LDI: begin
                            w_strobes.Zlowout = 1'b1; w_strobes.Gra = 1'b1; w_strobes.Rin = 1'b1;
                        end
                        CL_LD, CL_ST: begin
                            w_strobes.Zlowout = 1'b1; w_strobes.MARin = 1'b1;
                            w_step_adv = T6;
                        end
                        CL_MULDIV: begin
                            w_strobes.Zlowout = 1'b1; w_strobes.LOin = 1'b1;
                            w_step_adv = T6;
                        end
                        CL_BR: begin
                            w_strobes.Cout = 1'b1; w_strobes.Zin = 1'b1;
                            w_alu_ctl  = w_alu_op;
                            w_step_adv = T6;
                        end
                        default: w_step_adv = T0;
                    endcase
                end
                T6: begin
                    case (w_class)
                        CL_LD: begin
                            w_strobes.Read = 1'b1; w_strobes.MDRin = 1'b1;
                            w_step_adv = T7;
                        end
                        CL_ST: begin
                            w_strobes.Gra = 1'b1; w_strobes.Rout = 1'b1; w_strobes.MDRin = 1'b1;
                            w_step_adv = T7;
                        end
                        CL_MULDIV: begin
                            w_strobes.Zhighout = 1'b1; w_strobes.HIin = 1'b1;
                        end
                        CL_BR: begin
                            // branch target is written only when the condition holds
                            w_strobes.Zlowout = bus.con_ff; w_strobes.PCin = bus.con_ff;
                        end
                        default: w_step_adv = T0;
                    endcase
                end
                T7: begin
                    case (w_class)
                        CL_LD: begin
                            w_strobes.MDRout = 1'b1; w_strobes.Gra = 1'b1; w_strobes.Rin = 1'b1;
                        end
                        CL_ST:   w_strobes.Write = 1'b1;
                        default: w_step_adv = T0;
                    endcase
                end
                default: w_step_adv = T0;
            endcase
        end
        w_step_nxt = w_hold ? r_step : w_step_adv;
    end

    assign bus.strobes    = w_strobes;
    assign bus.aluControl = w_alu_ctl;
    assign bus.run        = (r_state == ST_RUN);
    assign bus.illegal    = r_illegal;

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized self-checking bench for control_sequencer. The reference model
// expands each instruction into the list of strobe sets it must produce,
// cycle by cycle, and tracks run/illegal across halts and clears.
module tb_control_sequencer;
    import cpu_ctrl_pkg::*;

    logic clock = 1'b0;
    logic clear;

    control_sequencer_if u_if ();

    control_sequencer u_dut (
        .clock (clock),
        .clear (clear),
        .bus   (u_if)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [26:0] s;
        logic [4:0]  alu;
        bit          mem;
        bit          halt;
        bit          ill;
    } exp_t;

    string STB_NAMES [27] = '{"PCout", "Zlowout", "Zhighout", "MDRout", "HIout",
                              "LOout", "InPortout", "Cout", "MARin", "Zin",
                              "PCin", "MDRin", "IRin", "Yin", "HIin",
                              "LOin", "OutPortin", "Read", "Write", "Gra",
                              "Grb", "Grc", "Rin", "Rout", "BAout",
                              "ConIn", "incPC"};

    exp_t q[$];
    int   n_checks    = 0;
    int   n_errors    = 0;
    bit   exp_run     = 1'b1;
    bit   exp_illegal = 1'b0;
    int   mem_lo_cnt  = 0;
    bit   mem_rand_en = 1'b1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, act, exp);
        end
    endtask

    // Turn a space-separated list of strobe names into a strobe vector.
    function automatic logic [26:0] f_sb(input string spec);
        logic [26:0] v;
        string tok;
        v   = '0;
        tok = "";
        for (int i = 0; i <= spec.len(); i++) begin
            if (i == spec.len() || spec[i] == 8'h20) begin
                for (int k = 0; k < 27; k++)
                    if (tok == STB_NAMES[k]) v[26-k] = 1'b1;
                tok = "";
            end else begin
                tok = {tok, spec.substr(i, i)};
            end
        end
        return v;
    endfunction

    function automatic logic [4:0] f_alu_of(input logic [4:0] op);
        case (op)
            OP_ADD, OP_ADDI: return ALU_ADD;
            OP_SUB:          return ALU_SUB;
            OP_AND, OP_ANDI: return ALU_AND;
            OP_OR, OP_ORI:   return ALU_OR;
            OP_SHR:          return ALU_SHR;
            OP_SHRA:         return ALU_SHRA;
            OP_SHL:          return ALU_SHL;
            OP_ROR:          return ALU_ROR;
            OP_ROL:          return ALU_ROL;
            OP_MUL:          return ALU_MUL;
            OP_DIV:          return ALU_DIV;
            OP_NEG:          return ALU_NEG;
            OP_NOT:          return ALU_NOT;
            default:         return ALU_ADD;
        endcase
    endfunction

    task automatic push(input string spec, input logic [4:0] alu, input bit mem);
        exp_t e;
        e.s = f_sb(spec); e.alu = alu; e.mem = mem; e.halt = 1'b0; e.ill = 1'b0;
        q.push_back(e);
    endtask

    task automatic push_halt(input bit ill);
        exp_t e;
        e.s = '0; e.alu = ALU_NONE; e.mem = 1'b0; e.halt = 1'b1; e.ill = ill;
        q.push_back(e);
    endtask

    // Cycle-by-cycle expectation for one instruction, fetch included.
    task automatic build_model(input logic [4:0] op, input logic con);
        q.delete();
        push("PCout MARin incPC", ALU_NONE, 1'b0);
        push("Read MDRin", ALU_NONE, 1'b1);
        push("MDRout IRin", ALU_NONE, 1'b0);
        if (op >= OP_ADD && op <= OP_ROL) begin
            push("Grb Rout Yin", ALU_NONE, 1'b0);
            push("Grc Rout Zin", f_alu_of(op), 1'b0);
            push("Zlowout Gra Rin", ALU_NONE, 1'b0);
        end else if (op >= OP_ADDI && op <= OP_ORI) begin
            push("Grb Rout Yin", ALU_NONE, 1'b0);
            push("Cout Zin", f_alu_of(op), 1'b0);
            push("Zlowout Gra Rin", ALU_NONE, 1'b0);
        end else if (op <= OP_ST) begin
            push("Grb BAout Yin", ALU_NONE, 1'b0);
            push("Cout Zin", ALU_ADD, 1'b0);
            if (op == OP_LDI) begin
                push("Zlowout Gra Rin", ALU_NONE, 1'b0);
            end else if (op == OP_LD) begin
                push("Zlowout MARin", ALU_NONE, 1'b0);
                push("Read MDRin", ALU_NONE, 1'b1);
                push("MDRout Gra Rin", ALU_NONE, 1'b0);
            end else begin
                push("Zlowout MARin", ALU_NONE, 1'b0);
                push("Gra Rout MDRin", ALU_NONE, 1'b0);
                push("Write", ALU_NONE, 1'b1);
            end
        end else begin
            case (op)
                OP_MUL, OP_DIV: begin
                    push("Gra Rout Yin", ALU_NONE, 1'b0);
                    push("Grb Rout Zin", f_alu_of(op), 1'b0);
                    push("Zlowout LOin", ALU_NONE, 1'b0);
                    push("Zhighout HIin", ALU_NONE, 1'b0);
                end
                OP_NEG, OP_NOT: begin
                    push("Grb Rout Zin", f_alu_of(op), 1'b0);
                    push("Zlowout Gra Rin", ALU_NONE, 1'b0);
                end
                OP_BR: begin
                    push("Gra Rout ConIn", ALU_NONE, 1'b0);
                    push("PCout Yin", ALU_NONE, 1'b0);
                    push("Cout Zin", ALU_ADD, 1'b0);
                    push(con ? "Zlowout PCin" : "", ALU_NONE, 1'b0);
                end
                OP_JR:   push("Gra Rout PCin", ALU_NONE, 1'b0);
                OP_IN:   push("InPortout Gra Rin", ALU_NONE, 1'b0);
                OP_OUT:  push("Gra Rout OutPortin", ALU_NONE, 1'b0);
                OP_MFHI: push("HIout Gra Rin", ALU_NONE, 1'b0);
                OP_MFLO: push("LOout Gra Rin", ALU_NONE, 1'b0);
                OP_NOP:  push("", ALU_NONE, 1'b0);
                OP_HALT: push_halt(1'b0);
                default: push_halt(1'b1);
            endcase
        end
    endtask

    task automatic check_outputs(input string tag, input logic [26:0] s, input logic [4:0] alu);
        check_eq({tag, "_strobes"}, 32'(u_if.strobes), 32'(s));
        check_eq({tag, "_alu"}, 32'(u_if.aluControl), 32'(alu));
        check_eq({tag, "_run"}, 32'(u_if.run), 32'(exp_run));
        check_eq({tag, "_illegal"}, 32'(u_if.illegal), 32'(exp_illegal));
    endtask

    // Run one instruction from T0; optional stop at T0 and clear at cycle clear_at.
    task automatic do_instr(input logic [4:0] op, input logic con, input bit stp, input int clear_at);
        logic [31:0] rnd;
        int          cyc;
        bit          mem_ok;
        bit          supp;
        exp_t        e;
        rnd = $urandom();
        build_model(op, con);
        cyc = 0;
        while (q.size() > 0 && cyc < 64) begin
            e = q[0];
            @(negedge clock);
            u_if.ir     = {op, rnd[26:0]};
            u_if.con_ff = con;
            u_if.stop   = (cyc == 0) ? stp : 1'($urandom_range(0, 1));
            clear       = (cyc == clear_at);
            mem_ok      = 1'b1;
`ifdef CTRL_MEM_WAIT_EN
            if (e.mem && mem_lo_cnt > 0) begin
                u_if.mem_ready = 1'b0;
                mem_lo_cnt--;
            end else if (mem_rand_en) begin
                u_if.mem_ready = ($urandom_range(0, 2) != 0);
            end else begin
                u_if.mem_ready = 1'b1;
            end
            mem_ok = u_if.mem_ready;
`endif
            #1;
            supp = clear || (cyc == 0 && stp);
            check_outputs("instr", supp ? 27'd0 : e.s, supp ? ALU_NONE : e.alu);
            if (clear) begin
                exp_run = 1'b1; exp_illegal = 1'b0; q.delete();
            end else if (cyc == 0 && stp) begin
                exp_run = 1'b0; q.delete();
            end else if (e.halt) begin
                exp_run = 1'b0; exp_illegal = exp_illegal | e.ill; q.delete();
            end else if (e.mem && !mem_ok) begin
                cyc = cyc;
            end else begin
                void'(q.pop_front());
            end
            cyc++;
        end
        if (q.size() > 0) check_eq("instr_timeout", 32'(q.size()), 32'd0);
    endtask

    task automatic idle_halted(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            clear     = 1'b0;
            u_if.stop = 1'($urandom_range(0, 1));
            u_if.ir   = $urandom();
            #1;
            check_outputs("halted", 27'd0, ALU_NONE);
        end
    endtask

    task automatic do_clear();
        @(negedge clock);
        clear     = 1'b1;
        u_if.stop = 1'b0;
        #1;
        check_outputs("clear", 27'd0, ALU_NONE);
        exp_run     = 1'b1;
        exp_illegal = 1'b0;
    endtask

    initial begin
        logic [4:0] op;
        int         clr_at;
        clear       = 1'b1;
        u_if.ir     = 32'h0;
        u_if.con_ff = 1'b0;
        u_if.stop   = 1'b0;
`ifdef CTRL_MEM_WAIT_EN
        u_if.mem_ready = 1'b1;
`endif
        @(negedge clock);
        #1;
        check_eq("reset_strobes_in_clear", 32'(u_if.strobes), 32'd0);
        @(negedge clock);
        #1;
        check_outputs("reset", 27'd0, ALU_NONE);

        // Directed: add, ld, ldi, st, br both ways, halt + 20 idle cycles.
        do_instr(OP_ADD, 1'b0, 1'b0, -1);
        do_instr(OP_LD, 1'b0, 1'b0, -1);
        do_instr(OP_LDI, 1'b0, 1'b0, -1);
        do_instr(OP_ST, 1'b0, 1'b0, -1);
        do_instr(OP_BR, 1'b0, 1'b0, -1);
        do_instr(OP_BR, 1'b1, 1'b0, -1);
        do_instr(OP_HALT, 1'b0, 1'b0, -1);
        idle_halted(20);
        do_clear();
        // Clear during T4 of mul: LOin/HIin must never appear.
        do_instr(OP_MUL, 1'b0, 1'b0, 4);
        do_instr(OP_ADD, 1'b1, 1'b0, -1);
        // Undefined opcode sets the sticky flag; stop at T0 halts before fetch.
        do_instr(5'h1F, 1'b0, 1'b0, -1);
        idle_halted(3);
        do_clear();
        do_instr(OP_SUB, 1'b0, 1'b1, -1);
        idle_halted(2);
        do_clear();
`ifdef CTRL_MEM_WAIT_EN
        // Memory wait: three not-ready cycles stretch fetch T1 to four cycles.
        mem_rand_en = 1'b0;
        mem_lo_cnt  = 3;
        do_instr(OP_ADD, 1'b0, 1'b0, -1);
        mem_lo_cnt  = 2;
        do_instr(OP_ST, 1'b0, 1'b0, -1);
        mem_rand_en = 1'b1;
`endif

        // Randomized instruction stream with occasional stop/clear.
        for (int n = 0; n < 80; n++) begin
            op     = 5'($urandom_range(0, 31));
            clr_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : -1;
            do_instr(op, 1'($urandom_range(0, 1)), ($urandom_range(0, 11) == 0), clr_at);
            if (!exp_run) begin
                idle_halted(int'($urandom_range(1, 4)));
                do_clear();
            end
        end

        @(negedge clock);
        clear = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
